// File: rtl/bus_arbiter.sv
// Round-robin arbiter for the shared internal bus with bounded locked ownership.
// Grant, grant_id, grant_valid and hold_timeout are all registered on the rising clock edge.
module bus_arbiter #(
  parameter int unsigned NUM_REQ  = 4,
  parameter int unsigned ID_WIDTH = 2,
  parameter int unsigned MAX_HOLD = 8
) (
  input  logic                clock,
  input  logic                clear,
  input  logic [NUM_REQ-1:0]  req,
  input  logic [NUM_REQ-1:0]  lock,
  output logic [NUM_REQ-1:0]  grant,
  output logic                grant_valid,
  output logic [ID_WIDTH-1:0] grant_id,
  output logic                hold_timeout
);

  localparam logic [7:0]          MaxHold = 8'(MAX_HOLD);
  localparam logic [ID_WIDTH-1:0] LastId  = ID_WIDTH'(NUM_REQ - 1);

  typedef enum logic [0:0] {StIdle, StOwn} state_e;

  state_e              state_q, state_d;
  logic [ID_WIDTH-1:0] ptr_q, ptr_d;
  logic [7:0]          cnt_q, cnt_d;
  logic [NUM_REQ-1:0]  grant_q, grant_d;
  logic [ID_WIDTH-1:0] id_q, id_d;
  logic                valid_q;
  logic                timeout_q, timeout_d;

  logic                owner_lock;
  logic                keep;
  logic                release_own;
  logic [ID_WIDTH-1:0] next_ptr;
  logic [ID_WIDTH-1:0] arb_start;

  logic                hi_found, lo_found, arb_found;
  logic [ID_WIDTH-1:0] hi_idx, lo_idx, arb_idx;
  logic [NUM_REQ-1:0]  hi_oh, lo_oh, arb_oh;

  // grant_q is one-hot, so masking avoids indexing by the owner id.
  assign owner_lock  = |(req & lock & grant_q);
  assign keep        = owner_lock && (cnt_q < MaxHold);
  assign release_own = (state_q == StOwn) && !keep;
  assign next_ptr    = (id_q == LastId) ? '0 : id_q + ID_WIDTH'(1);
  assign arb_start   = release_own ? next_ptr : ptr_q;

  // Lowest index at or above arb_start wins; otherwise the lowest index overall (wrap-around).
  always_comb begin
    hi_found = 1'b0;
    lo_found = 1'b0;
    hi_idx   = '0;
    lo_idx   = '0;
    hi_oh    = '0;
    lo_oh    = '0;
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      if (req[i]) begin
        lo_found  = 1'b1;
        lo_idx    = ID_WIDTH'(i);
        lo_oh     = '0;
        lo_oh[i]  = 1'b1;
        if (i >= int'(arb_start)) begin
          hi_found = 1'b1;
          hi_idx   = ID_WIDTH'(i);
          hi_oh    = '0;
          hi_oh[i] = 1'b1;
        end
      end
    end
    arb_found = lo_found;
    arb_idx   = hi_found ? hi_idx : lo_idx;
    arb_oh    = hi_found ? hi_oh : lo_oh;
  end

  always_comb begin
    state_d   = state_q;
    ptr_d     = ptr_q;
    cnt_d     = cnt_q;
    grant_d   = grant_q;
    id_d      = id_q;
    timeout_d = 1'b0;
    if (state_q == StIdle || release_own) begin
      if (release_own) begin
        ptr_d     = next_ptr;
        timeout_d = owner_lock;
      end
      if (arb_found) begin
        state_d = StOwn;
        cnt_d   = 8'd1;
        grant_d = arb_oh;
        id_d    = arb_idx;
      end else begin
        state_d = StIdle;
        cnt_d   = 8'd0;
        grant_d = '0;
        id_d    = '0;
      end
    end else begin
      cnt_d = cnt_q + 8'd1;
    end
  end

  always_ff @(posedge clock or posedge clear) begin
    if (clear) begin
      state_q   <= StIdle;
      ptr_q     <= '0;
      cnt_q     <= 8'd0;
      grant_q   <= '0;
      id_q      <= '0;
      valid_q   <= 1'b0;
      timeout_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      ptr_q     <= ptr_d;
      cnt_q     <= cnt_d;
      grant_q   <= grant_d;
      id_q      <= id_d;
      valid_q   <= |grant_d;
      timeout_q <= timeout_d;
    end
  end

  assign grant        = grant_q;
  assign grant_valid  = valid_q;
  assign grant_id     = id_q;
  assign hold_timeout = timeout_q;

endmodule

// File: tb/tb_bus_arbiter.sv
// Scoreboard bench for bus_arbiter: a rule-level model queues expected outputs per cycle,
// a monitor pops and compares them after each rising edge and checks the grant invariants.
module tb_bus_arbiter;

  localparam int NR = 4;
  localparam int IW = 2;
  localparam int MH = 8;

  logic          clock;
  logic          clear;
  logic [NR-1:0] req;
  logic [NR-1:0] lock;
  logic [NR-1:0] grant;
  logic          grant_valid;
  logic [IW-1:0] grant_id;
  logic          hold_timeout;

  bus_arbiter #(
    .NUM_REQ (NR),
    .ID_WIDTH(IW),
    .MAX_HOLD(MH)
  ) dut (
    .clock       (clock),
    .clear       (clear),
    .req         (req),
    .lock        (lock),
    .grant       (grant),
    .grant_valid (grant_valid),
    .grant_id    (grant_id),
    .hold_timeout(hold_timeout)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  typedef struct {
    logic [NR-1:0] g;
    logic [IW-1:0] id;
    logic          v;
    logic          to;
  } exp_t;

  exp_t exp_q[$];
  int   n_checks = 0;
  int   n_fail   = 0;

  // Reference model: owner index (-1 when idle), cycles held, round-robin start.
  int m_owner = -1;
  int m_cnt   = 0;
  int m_ptr   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
    end
  endtask

  task automatic model_reset();
    m_owner = -1;
    m_cnt   = 0;
    m_ptr   = 0;
    exp_q.delete();
  endtask

  // Computes the outputs visible after the next rising edge given the inputs held now.
  task automatic model_step(input logic [NR-1:0] r, input logic [NR-1:0] l);
    exp_t e;
    bit   arbitrate;
    e.to = 1'b0;
    arbitrate = 1'b1;
    if (m_owner >= 0) begin
      if (r[m_owner] && l[m_owner] && m_cnt < MH) begin
        m_cnt++;
        arbitrate = 1'b0;
      end else begin
        e.to    = r[m_owner] && l[m_owner];
        m_ptr   = (m_owner + 1) % NR;
        m_owner = -1;
      end
    end
    if (arbitrate) begin
      m_owner = -1;
      m_cnt   = 0;
      for (int k = 0; k < NR; k++) begin
        int idx;
        idx = (m_ptr + k) % NR;
        if (m_owner < 0 && r[idx]) begin
          m_owner = idx;
          m_cnt   = 1;
        end
      end
    end
    e.g  = (m_owner >= 0) ? NR'(1 << m_owner) : '0;
    e.id = (m_owner >= 0) ? IW'(m_owner) : '0;
    e.v  = (m_owner >= 0);
    exp_q.push_back(e);
  endtask

  task automatic drive(input logic [NR-1:0] r, input logic [NR-1:0] l);
    @(negedge clock);
    req  = r;
    lock = l;
    model_step(r, l);
  endtask

  // Monitor: compares queued expectations and invariants after every rising edge.
  initial begin
    forever begin
      @(posedge clock);
      #1;
      begin
        int  ones;
        int  idx;
        ones = 0;
        idx  = 0;
        for (int i = 0; i < NR; i++) if (grant[i]) begin ones++; idx = i; end
        chk("onehot0", 32'(ones <= 1), 32'd1);
        chk("valid_eq_or", 32'(grant_valid), 32'(|grant));
        if (ones == 1) chk("id_matches_bit", 32'(grant_id), 32'(idx));
      end
      if (exp_q.size() > 0) begin
        exp_t e;
        e = exp_q.pop_front();
        chk("grant", 32'(grant), 32'(e.g));
        chk("grant_id", 32'(grant_id), 32'(e.id));
        chk("grant_valid", 32'(grant_valid), 32'(e.v));
        chk("hold_timeout", 32'(hold_timeout), 32'(e.to));
      end
    end
  end

  initial begin
    clear = 1'b1;
    req   = '0;
    lock  = '0;
    #2;
    chk("rst_grant", 32'(grant), 32'd0);
    chk("rst_valid", 32'(grant_valid), 32'd0);
    chk("rst_id", 32'(grant_id), 32'd0);
    chk("rst_timeout", 32'(hold_timeout), 32'd0);
    @(negedge clock);
    clear = 1'b0;
    model_reset();

    // Round-robin fairness.
    repeat (8) drive(4'b1111, 4'b0000);
    // Single requester then idle.
    repeat (3) drive(4'b0100, 4'b0000);
    repeat (2) drive(4'b0000, 4'b0000);
    // Locked burst released by lock drop.
    repeat (3) drive(4'b1010, 4'b0010);
    repeat (3) drive(4'b1010, 4'b0000);
    repeat (2) drive(4'b0000, 4'b0000);
    // Hold timeout with a competitor.
    repeat (14) drive(4'b0101, 4'b0001);
    // Lone locked requester is re-granted after timeout.
    repeat (12) drive(4'b0001, 4'b0001);
    repeat (2) drive(4'b0000, 4'b0000);
    // Drop while granted.
    drive(4'b0011, 4'b0000);
    drive(4'b0010, 4'b0000);
    drive(4'b0010, 4'b0000);

    // Asynchronous clear in the middle of a cycle while index 1 is granted.
    drive(4'b0010, 4'b0010);
    drive(4'b0010, 4'b0010);
    @(posedge clock);
    #3;
    clear = 1'b1;
    #1;
    chk("async_clr_grant", 32'(grant), 32'd0);
    chk("async_clr_valid", 32'(grant_valid), 32'd0);
    chk("async_clr_id", 32'(grant_id), 32'd0);
    model_reset();
    @(negedge clock);
    clear = 1'b0;
    req   = 4'b1111;
    lock  = 4'b0000;
    model_step(4'b1111, 4'b0000);
    drive(4'b1111, 4'b0000);

    // Random traffic with persistent requests so locks and timeouts occur.
    begin
      logic [NR-1:0] r;
      logic [NR-1:0] l;
      r = '0;
      l = '0;
      for (int c = 0; c < 2000; c++) begin
        if ($urandom_range(3) == 0) r = NR'($urandom);
        if ($urandom_range(3) == 0) l = NR'($urandom);
        drive(r, l);
      end
    end
    drive(4'b0000, 4'b0000);

    begin
      int budget;
      budget = 10;
      while (exp_q.size() > 0 && budget > 0) begin
        @(posedge clock);
        budget--;
      end
      #2;
      chk("queue_drained", 32'(exp_q.size()), 32'd0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/bus_arbiter.md
Name: bus_arbiter

Overview:
- Round-robin arbiter that shares the CPU's single internal bus among NUM_REQ requesters: datapath registers, memory data path and ALU result.
- Issues one grant per cycle. The grant drives the winner's bus-output select and the winner's destination register enable.
- Supports locked multi-cycle ownership for transfers that span several cycles, bounded by a hold limit.
- Arbiter state updates on posedge clock. Datapath registers capture on negedge, so grant-derived enables are stable half a cycle before capture.

Parameters:
- NUM_REQ, 4, number of requesters (2..16).
- ID_WIDTH, 2, width of grant_id; must be at least ceil(log2(NUM_REQ)).
- MAX_HOLD, 8, maximum consecutive cycles one locked owner may hold the bus (1..255).

Ports:
- clock  input  1  system clock; all state updates on posedge.
- clear  input  1  asynchronous active-high reset.
- req  input  NUM_REQ  per-requester bus request, level-sensitive.
- lock  input  NUM_REQ  per-requester lock; requests continued ownership while req is also high.
- grant  output  NUM_REQ  one-hot grant, registered; all zeros when idle.
- grant_valid  output  1  OR of grant, registered.
- grant_id  output  ID_WIDTH  binary index of the granted requester; 0 when idle.
- hold_timeout  output  1  one-cycle pulse on the cycle a locked grant is forcibly released.

Behaviour:
- Reset: clear high forces, immediately and asynchronously:
  - grant=0, grant_valid=0, grant_id=0, hold_timeout=0
  - round-robin pointer ptr=0, hold counter cnt=0, state=IDLE
- Clear mid-grant drops the grant at once. After clear deasserts, arbitration restarts from ptr=0.
- States: IDLE, OWN.
- Selection function: the first index i with req[i]=1, searching ptr, ptr+1, ..., NUM_REQ-1, 0, ..., ptr-1.
- IDLE:
  - If any req is high at posedge: grant the selected index, go to OWN, cnt=1. Latency is one cycle from req sampled to grant visible.
  - Otherwise stay in IDLE with outputs zero.
- OWN, owner g, evaluated at each posedge:
  - Continue condition: req[g]&lock[g] and cnt<MAX_HOLD. Keep the grant and increment cnt. ptr is unchanged.
  - Otherwise release: set ptr=(g+1) mod NUM_REQ. Re-arbitrate in the same edge with the updated ptr over the current req vector, so back-to-back grants have zero idle cycles.
    - If a winner exists, grant it with cnt=1 and stay in OWN.
    - If no winner, go to IDLE.
- Without lock, every grant lasts exactly one cycle.
- Forced release: release because cnt==MAX_HOLD while req[g]&lock[g] is still high.
  - Assert hold_timeout for the single cycle following the edge that performs the release.
  - Requester g is not eligible again until every other requester asserting req in that arbitration has been served, which follows naturally from ptr=g+1.
  - If g is the only requester, it is re-granted on the next edge with a fresh cnt=1.
- Requester drops req while granted: its grant is removed at the next posedge. The current cycle's grant is never withdrawn combinationally.
- lock without req is ignored. lock changes mid-ownership take effect at the next edge.
- Invariants: grant is always one-hot or zero. grant_id always equals the index of the set grant bit. grant_valid always equals |grant.
- Wrap-around: ptr goes from NUM_REQ-1 to 0. cnt never exceeds MAX_HOLD.
- Requests for indices at or above NUM_REQ do not exist; width is exact.

Test Plan:
- Reset mid-operation: with req=4'b0010 granted, assert clear -> grant=0, grant_valid=0, grant_id=0 without waiting for a clock edge. Release clear with req=4'b1111 -> next posedge grant=4'b0001.
- Round-robin fairness: hold req=4'b1111, lock=0 for 8 cycles -> grant_id sequence 0,1,2,3,0,1,2,3 with grant_valid=1 on every cycle.
- Single requester: req=4'b0100 for 3 cycles, then 0 -> grant=4'b0100 for 3 cycles starting one cycle after req, then grant=0 and state IDLE.
- Locked burst: req[1]=lock[1]=1 with req[3]=1, MAX_HOLD=8, lock dropped after 3 cycles -> grant_id=1 for 3 cycles, then 3, with no idle gap and hold_timeout=0.
- Hold timeout: req[0]=lock[0]=1 and req[2]=1, all held -> grant_id=0 for exactly 8 cycles, hold_timeout pulses once, then grant_id=2, then 0 with cnt restarted.
- Drop while granted: req=4'b0011, req[0] deasserted during its grant cycle -> grant moves to index 1 at the next edge. Checker asserts the one-hot, grant_id and grant_valid invariants every cycle.
